// File: rtl/ecc_montmult_pkg.sv
// Shared types and sizing helpers for the Montgomery multiplier sequencer.
package ecc_montmult_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN,
    ST_COLLECT,
    ST_DONE
  } ecc_montmult_state_e;

  // One guard word on top of the operand words.
  function automatic int calc_s_num(input int reg_size, input int radix);
    return reg_size / radix + 1;
  endfunction

  localparam int DEF_RADIX       = 32;
  localparam int DEF_REG_SIZE    = 384;
  localparam int DEF_S_NUM       = calc_s_num(DEF_REG_SIZE, DEF_RADIX);
  localparam int DEF_RUN_LEN     = 2 * DEF_S_NUM;
  localparam int DEF_COLLECT_LEN = DEF_S_NUM;

endpackage

// File: rtl/ecc_montmult_ctrl.sv
// Sequencer for the systolic Montgomery PE array: clear pulse, word/phase
// stepping during the run, result-word capture walk and completion pulse.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for start_i; ready_o=1
// ST_INIT    | one-cycle PE clear (pe_start_o=1)
// ST_RUN     | 2*S_NUM cycles, odd toggles, a_idx steps after each odd=1
// ST_COLLECT | S_NUM cycles of result capture, res_idx 0..S_NUM-1
// ST_DONE    | one-cycle done_o pulse
module ecc_montmult_ctrl
  import ecc_montmult_pkg::*;
#(
  parameter  int RADIX    = DEF_RADIX,
  parameter  int REG_SIZE = DEF_REG_SIZE,
  localparam int S_NUM    = calc_s_num(REG_SIZE, RADIX),
  localparam int IDX_W    = $clog2(S_NUM)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             zeroize,
  input  logic             start_i,
  output logic             ready_o,
  output logic             pe_start_o,
  output logic             pe_odd_o,
  output logic [IDX_W-1:0] a_idx_o,
  output logic             res_we_o,
  output logic [IDX_W-1:0] res_idx_o,
  output logic             done_o
);

  if (REG_SIZE % RADIX != 0) begin : g_bad_reg_size
    $error("REG_SIZE must be a multiple of RADIX");
  end
  if (S_NUM > 2 ** IDX_W) begin : g_bad_idx_w
    $error("IDX_W too narrow for S_NUM");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(S_NUM - 1);

  ecc_montmult_state_e state_q, state_d;
  logic                odd_d;
  logic [IDX_W-1:0]    a_idx_d;
  logic [IDX_W-1:0]    res_idx_d;

  always_comb begin
    state_d   = state_q;
    odd_d     = 1'b0;
    a_idx_d   = '0;
    res_idx_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_INIT;
      end
      ST_INIT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // Word index advances only after the odd half of each word pair.
        if (!pe_odd_o) begin
          odd_d   = 1'b1;
          a_idx_d = a_idx_o;
        end else if (a_idx_o == LAST_IDX) begin
          state_d = ST_COLLECT;
        end else begin
          a_idx_d = a_idx_o + IDX_W'(1);
        end
      end
      ST_COLLECT: begin
        if (res_idx_o == LAST_IDX) state_d = ST_DONE;
        else                       res_idx_d = res_idx_o + IDX_W'(1);
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset || zeroize) begin
      state_q    <= ST_IDLE;
      ready_o    <= 1'b1;
      pe_start_o <= 1'b0;
      pe_odd_o   <= 1'b0;
      a_idx_o    <= '0;
      res_we_o   <= 1'b0;
      res_idx_o  <= '0;
      done_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_o    <= (state_d == ST_IDLE);
      pe_start_o <= (state_d == ST_INIT);
      pe_odd_o   <= odd_d;
      a_idx_o    <= a_idx_d;
      res_we_o   <= (state_d == ST_COLLECT);
      res_idx_o  <= res_idx_d;
      done_o     <= (state_d == ST_DONE);
    end
  end

endmodule

// File: tb/tb_ecc_montmult_ctrl.sv
// Self-checking bench: default (S_NUM=13) and 256-bit (S_NUM=9) instances
// driven together and compared every cycle against a timeline model.
module tb_ecc_montmult_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       zeroize = 1'b0;
  logic       start_i = 1'b0;

  logic       ready_a, pe_start_a, pe_odd_a, res_we_a, done_a;
  logic [3:0] a_idx_a, res_idx_a;
  logic       ready_b, pe_start_b, pe_odd_b, res_we_b, done_b;
  logic [3:0] a_idx_b, res_idx_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  bit act[2];
  int kk[2];
  int sn[2] = '{13, 9};

  int done_cnt_a, last_done_a, last_done_b, max_res_b, pe_start_cnt_a;

  always #5 clk = ~clk;

  ecc_montmult_ctrl u_dut_a (
    .clk(clk), .reset(reset), .zeroize(zeroize), .start_i(start_i),
    .ready_o(ready_a), .pe_start_o(pe_start_a), .pe_odd_o(pe_odd_a),
    .a_idx_o(a_idx_a), .res_we_o(res_we_a), .res_idx_o(res_idx_a),
    .done_o(done_a)
  );

  ecc_montmult_ctrl #(.RADIX(32), .REG_SIZE(256)) u_dut_b (
    .clk(clk), .reset(reset), .zeroize(zeroize), .start_i(start_i),
    .ready_o(ready_b), .pe_start_o(pe_start_b), .pe_odd_o(pe_odd_b),
    .a_idx_o(a_idx_b), .res_we_o(res_we_b), .res_idx_o(res_idx_b),
    .done_o(done_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected outputs k cycles after the accepting cycle, from the latency table.
  function automatic logic [12:0] exp_vec(input bit active, input int k, input int s);
    logic rdy, ps, od, we, dn;
    int   ai, ri;
    rdy = !active; ps = 1'b0; od = 1'b0; we = 1'b0; dn = 1'b0; ai = 0; ri = 0;
    if (active) begin
      if (k == 1) ps = 1'b1;
      else if (k <= 2 * s + 1) begin
        od = ((k - 2) % 2) == 1;
        ai = (k - 2) / 2;
      end else if (k <= 3 * s + 1) begin
        we = 1'b1;
        ri = k - 2 * s - 2;
      end else dn = 1'b1;
    end
    return {rdy, ps, od, 4'(ai), we, 4'(ri), dn};
  endfunction

  task automatic step();
    bit r, z, s;
    r = reset; z = zeroize; s = start_i;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (r || z) act[i] = 1'b0;
      else if (act[i]) begin
        kk[i]++;
        if (kk[i] == 3 * sn[i] + 3) act[i] = 1'b0;
      end else if (s) begin
        act[i] = 1'b1;
        kk[i]  = 1;
      end
    end
    #1;
    cyc++;
    check("vec_a", {ready_a, pe_start_a, pe_odd_a, a_idx_a, res_we_a, res_idx_a, done_a},
          exp_vec(act[0], kk[0], sn[0]));
    check("vec_b", {ready_b, pe_start_b, pe_odd_b, a_idx_b, res_we_b, res_idx_b, done_b},
          exp_vec(act[1], kk[1], sn[1]));
    if (done_a === 1'b1) begin done_cnt_a++; last_done_a = cyc; end
    if (done_b === 1'b1) last_done_b = cyc;
    if (pe_start_a === 1'b1) pe_start_cnt_a++;
    if (res_we_b === 1'b1 && int'(res_idx_b) > max_res_b) max_res_b = int'(res_idx_b);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_stats();
    done_cnt_a = 0; last_done_a = -1; last_done_b = -1; max_res_b = -1; pe_start_cnt_a = 0;
  endtask

  initial begin
    int t0;
    clear_stats();

    // Reset, then a long idle stretch
    run(2);
    reset = 1'b0;
    check("reset_ready", 32'(ready_a), 32'd1);
    run(50);
    check("idle_no_done", 32'(done_cnt_a), 32'd0);

    // Single operation on both widths
    clear_stats();
    start_i = 1'b1; t0 = cyc;
    step();
    start_i = 1'b0;
    check("init_pulse", 32'(pe_start_a), 32'd1);
    run(45);
    check("done_at_a", 32'(last_done_a - t0), 32'd41);
    check("done_cnt_a", 32'(done_cnt_a), 32'd1);
    check("pe_start_cnt", 32'(pe_start_cnt_a), 32'd1);
    check("done_at_b", 32'(last_done_b - t0), 32'd29);
    check("res_max_b", 32'(max_res_b), 32'd8);

    // Start pulses while busy are dropped
    clear_stats();
    start_i = 1'b1; t0 = cyc;
    step();
    start_i = 1'b0;
    while (cyc < t0 + 5) step();
    start_i = 1'b1; step(); start_i = 1'b0;
    while (cyc < t0 + 41) step();
    start_i = 1'b1; step(); start_i = 1'b0;
    check("busy_ready_t42", 32'(ready_a), 32'd1);
    while (cyc < t0 + 90) step();
    check("busy_done_cnt", 32'(done_cnt_a), 32'd1);
    check("busy_done_at", 32'(last_done_a - t0), 32'd41);

    // Zeroize in the middle of the run phase
    clear_stats();
    start_i = 1'b1; t0 = cyc;
    step();
    start_i = 1'b0;
    while (cyc < t0 + 15) step();
    zeroize = 1'b1; step(); zeroize = 1'b0;
    check("zero_ready", 32'(ready_a), 32'd1);
    run(60);
    check("zero_no_done", 32'(done_cnt_a), 32'd0);

    // Start held high: back-to-back operations
    clear_stats();
    start_i = 1'b1; t0 = cyc;
    run(90);
    start_i = 1'b0;
    check("b2b_done_cnt", 32'(done_cnt_a), 32'd2);
    check("b2b_last_done", 32'(last_done_a - t0), 32'd83);
    check("b2b_pe_starts", 32'(pe_start_cnt_a), 32'd3);
    reset = 1'b1; step(); reset = 1'b0;

    // Reset and zeroize each beat a coincident start
    start_i = 1'b1; reset = 1'b1; step();
    reset = 1'b0; start_i = 1'b0;
    check("rst_beats_start", 32'(ready_a), 32'd1);
    start_i = 1'b1; zeroize = 1'b1; step();
    zeroize = 1'b0; start_i = 1'b0;
    check("zero_beats_start", 32'(ready_a), 32'd1);
    run(3);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      start_i = ($urandom_range(0, 3) == 0);
      zeroize = ($urandom_range(0, 99) == 0);
      reset   = ($urandom_range(0, 199) == 0);
      step();
    end
    start_i = 1'b0; zeroize = 1'b0; reset = 1'b0;
    run(50);
    check("final_idle", 32'(ready_a), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
